// File: rtl/tc_channel_bank_pkg.sv
// tc_channel_bank_pkg
// Shared sizing constants, timer/counter type codes and the per-channel
// state record used by tc_channel and tc_channel_bank.
//   TC_NUM       number of timer/counter channels
//   TC_TYPE_LEN  width of each channel's type field
//   TC_ADDR_LEN  channel address width (preset write / readback select)
//   PRESET_W     preset and accumulator width
//   PRESCALE     clk cycles per tick when TC_TICK_PRESCALER_EN is defined
package tc_channel_bank_pkg;

  localparam int TC_NUM      = 8;
  localparam int TC_TYPE_LEN = 3;
  localparam int TC_ADDR_LEN = 3;
  localparam int PRESET_W    = 8;
  localparam int PRESCALE    = 1000;

  // Codes 5..7 are illegal: the channel holds acc and forces done low.
  typedef enum logic [TC_TYPE_LEN-1:0] {
    TC_TON = 3'd0,  // on-delay timer
    TC_TOF = 3'd1,  // off-delay timer
    TC_TP  = 3'd2,  // pulse timer
    TC_CTU = 3'd3,  // up counter
    TC_CTD = 3'd4   // down counter
  } tc_type_e;

  // Complete registered state of one channel. type_d is the channel's mode
  // state; it is kept as raw bits so illegal codes are representable.
  typedef struct packed {
    logic [TC_TYPE_LEN-1:0] type_d;
    logic                   en_d;
    logic                   cnt_d;
    logic [PRESET_W-1:0]    acc;
    logic                   done;
  } tc_ch_state_t;

endpackage

// File: rtl/tc_channel.sv
// tc_channel
// One timer/counter channel: accumulator, done flag, enable/count edge
// registers and the type (mode) register. Every register lives in the
// state record st_q so the whole channel state is observable as one signal.
//   clk, rst  clock, asynchronous active-high reset
//   en        channel enable
//   cnt       count input (rising-edge sensitive, counter modes)
//   tick      one-cycle time-base pulse (timer modes)
//   typ       requested mode (tc_type_e code)
//   preset    programmed preset for this channel
//   acc       accumulator (registered)
//   done      done flag (registered, computed from the next-state acc)
module tc_channel
  import tc_channel_bank_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   cnt,
  input  logic                   tick,
  input  logic [TC_TYPE_LEN-1:0] typ,
  input  logic [PRESET_W-1:0]    preset,
  output logic [PRESET_W-1:0]    acc,
  output logic                   done
);

  localparam logic [PRESET_W-1:0] ACC_ONE = PRESET_W'(1);
  localparam logic [PRESET_W-1:0] ACC_MAX = '1;

  tc_ch_state_t st_q, st_d;
  logic         en_rise, cnt_rise;

  always_comb begin
    en_rise     = en & ~st_q.en_d;
    cnt_rise    = cnt & ~st_q.cnt_d;
    st_d        = st_q;
    st_d.en_d   = en;
    st_d.cnt_d  = cnt;
    st_d.type_d = typ;
    if (typ != st_q.type_d) begin
      // A mode change wipes the channel and swallows every other event.
      st_d.acc  = '0;
      st_d.done = 1'b0;
    end else begin
      case (st_q.type_d)
        TC_TON: begin
          if (!en) begin
            st_d.acc  = '0;
            st_d.done = 1'b0;
          end else begin
            if (tick && (st_q.acc < preset)) st_d.acc = st_q.acc + ACC_ONE;
            st_d.done = (st_d.acc >= preset);
          end
        end
        TC_TOF: begin
          if (en) begin
            st_d.acc  = '0;
            st_d.done = 1'b1;
          end else if (st_q.done) begin
            if (tick) st_d.acc = st_q.acc + ACC_ONE;
            // >= rather than == so a preset lowered below acc still ends it.
            st_d.done = (st_d.acc < preset);
          end
        end
        TC_TP: begin
          if (!st_q.done) begin
            if (en_rise) begin
              st_d.acc  = '0;
              st_d.done = 1'b1;
            end
          end else begin
            if (tick) st_d.acc = st_q.acc + ACC_ONE;
            st_d.done = (st_d.acc < preset);
          end
        end
        TC_CTU: begin
          if (!en) begin
            st_d.acc  = '0;
            st_d.done = 1'b0;
          end else begin
            if (cnt_rise && (st_q.acc != ACC_MAX)) st_d.acc = st_q.acc + ACC_ONE;
            st_d.done = (st_d.acc >= preset);
          end
        end
        TC_CTD: begin
          if (!en) begin
            st_d.acc  = preset;
            st_d.done = (preset == '0);
          end else begin
            if (cnt_rise && (st_q.acc != '0)) st_d.acc = st_q.acc - ACC_ONE;
            st_d.done = (st_d.acc == '0);
          end
        end
        default: st_d.done = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= '0;
    else     st_q <= st_d;
  end

  assign acc  = st_q.acc;
  assign done = st_q.done;

endmodule

// File: rtl/tc_channel_bank.sv
// tc_channel_bank
// Eight independent timer/counter channels with a preset register file and
// an accumulator readback mux.
//   clk          system clock
//   reset        asynchronous active-high reset (clears presets too)
//   tick         external time-base pulse (absent with TC_TICK_PRESCALER_EN)
//   en_in        per-channel enable
//   type_in      packed per-channel mode, channel i at [3i+2:3i]
//   cnt_in       per-channel count inputs (rising-edge sensitive)
//   preset_wr    preset write strobe; preset_addr/preset_data select/value
//   rd_addr      accumulator readback select
//   acc_out      accumulator of channel rd_addr (combinational mux)
//   done_out     per-channel done flags (registered)
// Build option: define TC_TICK_PRESCALER_EN to drop the tick port and derive
// the tick from an internal divide-by-PRESCALE counter.
module tc_channel_bank
  import tc_channel_bank_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
`ifndef TC_TICK_PRESCALER_EN
  input  logic                          tick,
`endif
  input  logic [TC_NUM-1:0]             en_in,
  input  logic [TC_NUM*TC_TYPE_LEN-1:0] type_in,
  input  logic [TC_NUM-1:0]             cnt_in,
  input  logic                          preset_wr,
  input  logic [TC_ADDR_LEN-1:0]        preset_addr,
  input  logic [PRESET_W-1:0]           preset_data,
  input  logic [TC_ADDR_LEN-1:0]        rd_addr,
  output logic [PRESET_W-1:0]           acc_out,
  output logic [TC_NUM-1:0]             done_out
);

  logic                tick_int;
  logic [PRESET_W-1:0] preset_q [TC_NUM];
  logic [PRESET_W-1:0] acc_q    [TC_NUM];

`ifdef TC_TICK_PRESCALER_EN
  localparam int                PS_W    = $clog2(PRESCALE);
  localparam logic [PS_W-1:0]   PS_LAST = PS_W'(PRESCALE - 1);
  logic [PS_W-1:0] ps_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 ps_cnt <= '0;
    else if (ps_cnt == PS_LAST) ps_cnt <= '0;
    else                       ps_cnt <= ps_cnt + PS_W'(1);
  end

  assign tick_int = (ps_cnt == PS_LAST);
`else
  assign tick_int = tick;
`endif

  // A write takes effect from the following edge; channels compare against
  // the value held in preset_q, i.e. the old preset on the write edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TC_NUM; i++) preset_q[i] <= '0;
    end else if (preset_wr) begin
      preset_q[preset_addr] <= preset_data;
    end
  end

  for (genvar i = 0; i < TC_NUM; i++) begin : g_ch
    tc_channel u_ch (
      .clk    (clk),
      .rst    (reset),
      .en     (en_in[i]),
      .cnt    (cnt_in[i]),
      .tick   (tick_int),
      .typ    (type_in[i*TC_TYPE_LEN +: TC_TYPE_LEN]),
      .preset (preset_q[i]),
      .acc    (acc_q[i]),
      .done   (done_out[i])
    );
  end

  assign acc_out = acc_q[rd_addr];

endmodule

// File: tb/tb_tc_channel_bank.sv
// tb_tc_channel_bank
// Directed bench for tc_channel_bank: one linear sequence of steps, each
// checked with an immediate assertion against hand-computed values.
module tb_tc_channel_bank;

  logic        clk;
  logic        reset;
  logic        tick;
  logic [7:0]  en_in;
  logic [23:0] type_in;
  logic [7:0]  cnt_in;
  logic        preset_wr;
  logic [2:0]  preset_addr;
  logic [7:0]  preset_data;
  logic [2:0]  rd_addr;
  logic [7:0]  acc_out;
  logic [7:0]  done_out;

  int compared   = 0;
  int mismatched = 0;

  tc_channel_bank dut (
    .clk         (clk),
    .reset       (reset),
`ifndef TC_TICK_PRESCALER_EN
    .tick        (tick),
`endif
    .en_in       (en_in),
    .type_in     (type_in),
    .cnt_in      (cnt_in),
    .preset_wr   (preset_wr),
    .preset_addr (preset_addr),
    .preset_data (preset_data),
    .rd_addr     (rd_addr),
    .acc_out     (acc_out),
    .done_out    (done_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_preset(input int ch, input logic [7:0] d);
    preset_wr   = 1'b1;
    preset_addr = ch[2:0];
    preset_data = d;
    step();
    preset_wr   = 1'b0;
  endtask

  task automatic set_type(input int ch, input logic [2:0] t);
    type_in[ch*3 +: 3] = t;
  endtask

  task automatic pulse_cnt(input int ch);
    cnt_in[ch] = 1'b1;
    step();
    cnt_in[ch] = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; en_in = '0; type_in = '0; cnt_in = '0;
    preset_wr = 1'b0; preset_addr = '0; preset_data = '0; rd_addr = '0;
    step(); step();
    chk("reset_acc", acc_out, 0);
    chk("reset_done", done_out, 0);
    reset = 1'b0;
    step();
    chk("post_reset_done", done_out, 0);

    wr_preset(2, 8'd3);
    wr_preset(5, 8'd2);
    wr_preset(0, 8'd4);
    wr_preset(7, 8'd2);
    wr_preset(3, 8'd2);

    // TON on channel 2
    rd_addr = 3'd2; en_in[2] = 1'b1; tick = 1'b1;
    step(); chk("ton_acc1", acc_out, 1); chk("ton_done1", done_out, 8'h00);
    step(); chk("ton_acc2", acc_out, 2);
    step(); chk("ton_acc3", acc_out, 3); chk("ton_done3", done_out, 8'h04);
    step(); chk("ton_hold", acc_out, 3);
    en_in[2] = 1'b0;
    step(); chk("ton_off_acc", acc_out, 0); chk("ton_off_done", done_out, 8'h00);
    tick = 1'b0;

    // TOF on channel 5
    set_type(5, 3'd1); rd_addr = 3'd5;
    step(); step(); chk("tof_idle_done", done_out[5], 0);
    en_in[5] = 1'b1;
    step(); chk("tof_en_done", done_out[5], 1);
    en_in[5] = 1'b0;
    step(); chk("tof_fall_done", done_out[5], 1);
    tick = 1'b1; step(); tick = 1'b0; step();
    chk("tof_tick1_done", done_out[5], 1); chk("tof_tick1_acc", acc_out, 1);
    tick = 1'b1; step(); tick = 1'b0;
    chk("tof_tick2_done", done_out[5], 0); chk("tof_tick2_acc", acc_out, 2);
    step(); chk("tof_hold_acc", acc_out, 2);

    // TP on channel 0
    set_type(0, 3'd2); rd_addr = 3'd0; tick = 1'b1;
    step();
    en_in[0] = 1'b1; step();
    chk("tp_start_done", done_out[0], 1); chk("tp_start_acc", acc_out, 0);
    en_in[0] = 1'b0; step();
    en_in[0] = 1'b1; step();
    en_in[0] = 1'b0; step();
    chk("tp_noretrig_done", done_out[0], 1); chk("tp_noretrig_acc", acc_out, 3);
    step(); chk("tp_end_done", done_out[0], 0); chk("tp_end_acc", acc_out, 4);
    step(); chk("tp_idle_acc", acc_out, 4);
    en_in[0] = 1'b1; step();
    chk("tp_retrig_done", done_out[0], 1); chk("tp_retrig_acc", acc_out, 0);
    en_in[0] = 1'b0;
    repeat (4) step();
    chk("tp_retrig_end", done_out[0], 0);
    tick = 1'b0;

    // CTU on channel 7
    set_type(7, 3'd3); rd_addr = 3'd7; en_in[7] = 1'b1;
    step(); step();
    chk("ctu_start_acc", acc_out, 0);
    pulse_cnt(7); chk("ctu_c1_done", done_out[7], 0);
    pulse_cnt(7); chk("ctu_c2_done", done_out[7], 1); chk("ctu_c2_acc", acc_out, 2);
    pulse_cnt(7); chk("ctu_c3_acc", acc_out, 3); chk("ctu_c3_done", done_out[7], 1);
    wr_preset(7, 8'd255);
    chk("ctu_wr_edge_done", done_out[7], 1);
    step(); chk("ctu_new_preset_done", done_out[7], 0);
    repeat (300) pulse_cnt(7);
    chk("ctu_sat_acc", acc_out, 255); chk("ctu_sat_done", done_out[7], 1);

    // CTD on channel 3, then change to CTU
    set_type(3, 3'd4); rd_addr = 3'd3;
    step(); step();
    chk("ctd_load_acc", acc_out, 2); chk("ctd_load_done", done_out[3], 0);
    en_in[3] = 1'b1;
    pulse_cnt(3); chk("ctd_c1_acc", acc_out, 1);
    pulse_cnt(3); chk("ctd_c2_acc", acc_out, 0); chk("ctd_c2_done", done_out[3], 1);
    set_type(3, 3'd3); cnt_in[3] = 1'b1;
    step(); chk("type_chg_acc", acc_out, 0); chk("type_chg_done", done_out[3], 0);
    step(); chk("type_chg_after_acc", acc_out, 0);
    cnt_in[3] = 1'b0; en_in[3] = 1'b0;

    // preset write racing a TON compare on channel 1
    wr_preset(1, 8'd3);
    rd_addr = 3'd1; en_in[1] = 1'b1; tick = 1'b1;
    step(); step();
    preset_wr = 1'b1; preset_addr = 3'd1; preset_data = 8'd5;
    step(); preset_wr = 1'b0;
    chk("race_old_done", done_out[1], 1); chk("race_old_acc", acc_out, 3);
    step(); chk("race_new_done", done_out[1], 0); chk("race_new_acc", acc_out, 4);
    tick = 1'b0;
    wr_preset(1, 8'd2);
    chk("lower_wr_edge_done", done_out[1], 0);
    step(); chk("lower_next_done", done_out[1], 1);

    // asynchronous reset between clock edges
    rd_addr = 3'd7;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_acc", acc_out, 0);
    chk("async_rst_done", done_out, 0);
    step();
    reset = 1'b0;
    step(); step();
    // CTU with en=1 and a cleared preset of 0 reports done immediately.
    chk("rst_preset_cleared", done_out[7], 1);
    chk("rst_ctu_acc", acc_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
